// File: rtl/histogram_mc_if.sv
// Sample-side handshake bundle for histogram_mc: the producer drives samples,
// the histogram reports when it is ready to take them.
interface histogram_mc_if #(
    parameter int IN_WIDTH = 10,
    parameter int CH_BITS  = 1
);
    logic [IN_WIDTH-1:0] data_in;
    logic [CH_BITS-1:0]  ch_in;
    logic                valid_in;
    logic                ready_out;

    modport master (output data_in, ch_in, valid_in, input ready_out);
    modport slave  (input data_in, ch_in, valid_in, output ready_out);
endinterface

// File: rtl/histogram_mc.sv
// Multi-channel histogram: NCH interleaved channels share one RAM laid out as
// {channel, bin}, with a two-stage read-modify-write update path and a clear sweep.
module histogram_mc #(
    parameter int IN_WIDTH  = 10,
    parameter int BIN_BITS  = 6,
    parameter int CNT_BITS  = 8,
    parameter int CH_BITS   = 1,
    parameter int SAMP_BITS = 16
) (
    input  logic                          clk_w,
    input  logic                          rst_n,
    histogram_mc_if.slave                 smp,
    input  logic                          clear_in,
    input  logic                          sat_mode,
    input  logic [SAMP_BITS-1:0]          sample_limit,
    input  logic                          clk_r,
    input  logic [CH_BITS-1:0]            raddr_ch,
    input  logic [BIN_BITS-1:0]           raddr_bin,
    output logic [CNT_BITS-1:0]           rdata_out,
    output logic [(1<<CH_BITS)-1:0]       full_out,
    output logic [(1<<CH_BITS)-1:0]       ovf_out,
    output logic [(1<<CH_BITS)*BIN_BITS-1:0] peak_bin_out,
    output logic [(1<<CH_BITS)*CNT_BITS-1:0] peak_cnt_out
);

    localparam int NCH    = 1 << CH_BITS;
    localparam int ADDR_W = CH_BITS + BIN_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     clear_addr;
    logic                  clear_old;
    logic                  ready_q;
    logic                  s1_valid;
    logic [CH_BITS-1:0]    s1_ch;
    logic [BIN_BITS-1:0]   s1_bin;
    logic [SAMP_BITS-1:0]  samp_cnt [NCH];
    logic [NCH-1:0]        ovf_q;
    logic [BIN_BITS-1:0]   peak_bin [NCH];
    logic [CNT_BITS-1:0]   peak_cnt [NCH];
    logic [CNT_BITS-1:0]   mem [DEPTH];

    logic                  clear_edge;
    logic [BIN_BITS-1:0]   in_bin;
    logic                  accept;
    logic [ADDR_W-1:0]     s2_addr;
    logic [CNT_BITS-1:0]   rmw_old;
    logic                  rmw_at_max;
    logic [CNT_BITS-1:0]   rmw_new;

    // Decimation keeps only the MSBs of the sample as the bin index.
    assign clear_edge = clear_in & ~clear_old;
    assign in_bin     = smp.data_in[IN_WIDTH-1 -: BIN_BITS];
    assign accept     = smp.valid_in && (state == ST_IDLE) && !clear_edge
                        && !full_out[smp.ch_in];

    assign s2_addr    = {s1_ch, s1_bin};
    assign rmw_old    = mem[s2_addr];
    assign rmw_at_max = (rmw_old == {CNT_BITS{1'b1}});
    assign rmw_new    = rmw_at_max ? (sat_mode ? {CNT_BITS{1'b1}} : '0)
                                   : rmw_old + CNT_BITS'(1);

    always_comb begin
        full_out = '0;
        for (int c = 0; c < NCH; c++) begin
            full_out[c] = (sample_limit != '0) && (samp_cnt[c] >= sample_limit);
        end
    end

    // Control state; anything cleared by the sweep is forced to zero in ST_CLEAR.
    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clear_addr <= '0;
            clear_old  <= 1'b0;
            ready_q    <= 1'b0;
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_bin     <= '0;
            ovf_q      <= '0;
            for (int c = 0; c < NCH; c++) begin
                samp_cnt[c] <= '0;
                peak_bin[c] <= '0;
                peak_cnt[c] <= '0;
            end
        end else begin
            clear_old <= clear_in;
            s1_valid  <= accept;
            if (accept) begin
                s1_ch  <= smp.ch_in;
                s1_bin <= in_bin;
                if (samp_cnt[smp.ch_in] != {SAMP_BITS{1'b1}}) begin
                    samp_cnt[smp.ch_in] <= samp_cnt[smp.ch_in] + SAMP_BITS'(1);
                end
            end
            if (s1_valid) begin
                if (rmw_at_max) begin
                    ovf_q[s1_ch] <= 1'b1;
                end
                if (rmw_new > peak_cnt[s1_ch]) begin
                    peak_cnt[s1_ch] <= rmw_new;
                    peak_bin[s1_ch] <= s1_bin;
                end
            end
            case (state)
                ST_CLEAR: begin
                    clear_addr <= clear_addr + ADDR_W'(1);
                    ovf_q      <= '0;
                    for (int c = 0; c < NCH; c++) begin
                        samp_cnt[c] <= '0;
                        peak_bin[c] <= '0;
                        peak_cnt[c] <= '0;
                    end
                    if (clear_addr == {ADDR_W{1'b1}}) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_edge) begin
                        state      <= ST_CLEAR;
                        ready_q    <= 1'b0;
                        clear_addr <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Port A: sweep writes zeros, otherwise the stage-2 update lands here.
    always_ff @(posedge clk_w) begin
        if (state == ST_CLEAR) begin
            mem[clear_addr] <= '0;
        end else if (s1_valid) begin
            mem[s2_addr] <= rmw_new;
        end
    end

    assign rdata_out     = mem[{raddr_ch, raddr_bin}];
    assign smp.ready_out = ready_q;
    assign ovf_out       = ovf_q;

    for (genvar c = 0; c < NCH; c++) begin : g_pack
        assign peak_bin_out[c*BIN_BITS +: BIN_BITS] = peak_bin[c];
        assign peak_cnt_out[c*CNT_BITS +: CNT_BITS] = peak_cnt[c];
    end

    // Port B is an asynchronous read, so its clock and the decimated LSBs go nowhere.
    wire unused_ok = &{1'b0, clk_r, smp.data_in[IN_WIDTH-BIN_BITS-1:0]};

endmodule
